// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter that shares one sync_fifo write port among NUM_REQ producers.
// Each written word is tagged with its source ID. The grant is held for one packet, up to MAX_BURST beats.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 2,
   parameter int MAX_BURST  = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
   input  logic [NUM_REQ-1:0]             req_last,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           fifo_wr_en,
   output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_data_in,
   input  logic                           fifo_full,
   output logic [ID_WIDTH-1:0]            grant_id,
   output logic                           busy
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   typedef enum logic {IDLE, BURST} state_e;

   state_e                state_q;
   logic [ID_WIDTH-1:0]   grant_id_q;
   logic [ID_WIDTH-1:0]   last_grant_q;
   logic [CNT_W-1:0]      beat_cnt_q;

   logic [ID_WIDTH-1:0]   arb_idx_d;
   logic                  arb_hit_d;
   int unsigned           arb_best;
   int unsigned           arb_dist;
   int unsigned           last_u;

   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  in_burst;
   logic                  wr_fire;

   // The winner is the valid requester at the smallest rotational distance past last_grant.
   always_comb begin
      arb_hit_d = 1'b0;
      arb_idx_d = '0;
      arb_best  = NUM_REQ;
      arb_dist  = 0;
      last_u    = 32'(last_grant_q);
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         arb_dist = (j + NUM_REQ - 1 - last_u) % NUM_REQ;
         if (req_valid[j] && (arb_dist < arb_best)) begin
            arb_best  = arb_dist;
            arb_idx_d = ID_WIDTH'(j);
            arb_hit_d = 1'b1;
         end
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      req_ready = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (grant_id_q == ID_WIDTH'(j)) begin
            sel_valid    = req_valid[j];
            sel_last     = req_last[j];
            sel_data     = req_data[j*DATA_WIDTH +: DATA_WIDTH];
            req_ready[j] = in_burst && !fifo_full;
         end
      end
   end

   assign in_burst     = (state_q == BURST);
   assign wr_fire      = in_burst && sel_valid && !fifo_full;
   assign fifo_wr_en   = wr_fire;
   assign fifo_data_in = in_burst ? {grant_id_q, sel_data} : '0;
   assign grant_id     = grant_id_q;
   assign busy         = in_burst;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_id_q   <= '0;
         beat_cnt_q   <= '0;
         last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_hit_d) begin
                  grant_id_q <= arb_idx_d;
                  beat_cnt_q <= '0;
                  state_q    <= BURST;
               end
            end
            BURST: begin
               if (wr_fire) begin
                  // The count saturates at MAX_BURST because the burst always exits on that beat.
                  beat_cnt_q <= beat_cnt_q + 1'b1;
                  if (sel_last || (beat_cnt_q == CNT_LAST)) begin
                     state_q      <= IDLE;
                     last_grant_q <= grant_id_q;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter. It uses a packet-level round-robin reference model
// and per-requester beat queues.
module tb_fifo_wr_arbiter;

   localparam int NR   = 4;
   localparam int DW   = 32;
   localparam int IW   = 2;
   localparam int MB   = 8;
   localparam int NCYC = 4000;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_last;
   logic [NR-1:0]    req_ready;
   logic             fifo_wr_en;
   logic [IW+DW-1:0] fifo_data_in;
   logic             fifo_full;
   logic [IW-1:0]    grant_id;
   logic             busy;

   typedef struct {
      logic [DW-1:0] d;
      bit            last;
   } beat_t;

   typedef struct {
      bit            wr;
      logic [IW+DW-1:0] data;
      logic [NR-1:0] rdy;
      bit            busy;
      logic [IW-1:0] gid;
   } exp_t;

   beat_t bq [NR][$];
   exp_t  sb [$];
   exp_t  mon_e;

   int vectors = 0;
   int miscompares = 0;

   bit m_busy;
   int m_gid;
   int m_cnt;
   int m_last;
   bit did_rst;

   fifo_wr_arbiter #(
      .NUM_REQ   (NR),
      .DATA_WIDTH(DW),
      .ID_WIDTH  (IW),
      .MAX_BURST (MB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_data_in(fifo_data_in),
      .fifo_full   (fifo_full),
      .grant_id    (grant_id),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   task automatic model_reset();
      m_busy = 1'b0;
      m_gid  = 0;
      m_cnt  = 0;
      m_last = NR - 1;
   endtask

   task automatic drive_inputs(input int pv, input int pf);
      int    len;
      bit    nolast;
      beat_t b;
      fifo_full = ($urandom_range(0, 99) < pf);
      for (int i = 0; i < NR; i++) begin
         if (bq[i].size() == 0 && $urandom_range(0, 3) != 0) begin
            len    = $urandom_range(1, 12);
            nolast = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < len; k++) begin
               b.d    = $urandom;
               b.last = !nolast && (k == len - 1);
               bq[i].push_back(b);
            end
         end
         if (bq[i].size() > 0 && $urandom_range(0, 99) < pv) begin
            req_valid[i]           = 1'b1;
            req_data[i*DW +: DW]   = bq[i][0].d;
            req_last[i]            = bq[i][0].last;
         end else begin
            req_valid[i]           = 1'b0;
            req_data[i*DW +: DW]   = $urandom;
            req_last[i]            = 1'($urandom_range(0, 1));
         end
      end
   endtask

   // Expected outputs for the current cycle are queued first. The model then advances to the next edge.
   task automatic model_step();
      exp_t  e;
      beat_t b;
      bit    found;
      int    c;
      e.busy = m_busy;
      e.gid  = IW'(m_gid);
      e.rdy  = '0;
      e.wr   = 1'b0;
      e.data = '0;
      if (m_busy) begin
         if (!fifo_full) e.rdy[m_gid] = 1'b1;
         e.wr   = req_valid[m_gid] && !fifo_full;
         e.data = {IW'(m_gid), req_data[m_gid*DW +: DW]};
      end
      sb.push_back(e);
      if (m_busy) begin
         if (e.wr) begin
            b = bq[m_gid].pop_front();
            m_cnt++;
            if (b.last || m_cnt == MB) begin
               m_busy = 1'b0;
               m_last = m_gid;
            end
         end
      end else begin
         found = 1'b0;
         for (int k = 1; k <= NR; k++) begin
            c = (m_last + k) % NR;
            if (!found && req_valid[c]) begin
               found  = 1'b1;
               m_gid  = c;
               m_cnt  = 0;
               m_busy = 1'b1;
            end
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  64'(busy),         64'(0));
      check({tag, "_wr_en"}, 64'(fifo_wr_en),   64'(0));
      check({tag, "_ready"}, 64'(req_ready),    64'(0));
      check({tag, "_gid"},   64'(grant_id),     64'(0));
      check({tag, "_data"},  64'(fifo_data_in), 64'(0));
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("wr_en",     64'(fifo_wr_en), 64'(mon_e.wr));
            if (mon_e.wr) check("data_in", 64'(fifo_data_in), 64'(mon_e.data));
            check("req_ready", 64'(req_ready),  64'(mon_e.rdy));
            check("busy",      64'(busy),       64'(mon_e.busy));
            check("grant_id",  64'(grant_id),   64'(mon_e.gid));
         end
      end
   end

   initial begin
      int pv;
      int pf;
      req_valid = '1;
      req_data  = '1;
      req_last  = '0;
      fifo_full = 1'b0;
      did_rst   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         if (cyc < 1000)      begin pv = 70;  pf = 20; end
         else if (cyc < 2000) begin pv = 100; pf = 0;  end
         else if (cyc < 3000) begin pv = 50;  pf = 40; end
         else                 begin pv = 90;  pf = 10; end
         if (!did_rst && cyc >= 2500 && m_busy) begin
            did_rst = 1'b1;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midrst");
            model_reset();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end
         drive_inputs(pv, pf);
         model_step();
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
